// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: operation codes, result classes
// and divider state encodings.
package ex_pkg;

    localparam int ALU_OP_W  = 8;
    localparam int ALU_SEL_W = 3;
    localparam int REG_W     = 32;
    localparam int REG_ADR_W = 5;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Iterative 32-step restoring divider with operand latch and sign fix-up.
// result = {remainder, quotient}; ready is high for the single END cycle.
module ex_div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] result,
    output logic        ready
);

    div_state_e  state_r;
    div_state_e  state_nxt_s;
    logic [5:0]  cnt_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] divisor_r;
    logic        neg_quo_r;
    logic        neg_rem_r;
    logic [32:0] partial_s;
    logic [32:0] diff_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping start (annul) abandons an in-flight divide
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start && !annul) begin
                    if (opb == 32'd0) begin
                        state_nxt_s = DIV_BYZERO;
                    end else begin
                        state_nxt_s = DIV_ON;
                    end
                end else begin
                    state_nxt_s = DIV_IDLE;
                end
            end
            DIV_BYZERO: begin
                if (annul) begin
                    state_nxt_s = DIV_IDLE;
                end else begin
                    state_nxt_s = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul) begin
                    state_nxt_s = DIV_IDLE;
                end else if (cnt_r == 6'd31) begin
                    state_nxt_s = DIV_END;
                end else begin
                    state_nxt_s = DIV_ON;
                end
            end
            DIV_END: state_nxt_s = DIV_IDLE;
            default: state_nxt_s = DIV_IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        partial_s = {rem_r, quo_r[31]};
        diff_s    = partial_s - {1'b0, divisor_r};
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= 6'd0;
            quo_r     <= 32'd0;
            rem_r     <= 32'd0;
            divisor_r <= 32'd0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start && !annul && (opb != 32'd0)) begin
                        cnt_r     <= 6'd0;
                        rem_r     <= 32'd0;
                        quo_r     <= (signed_div && opa[31]) ? (32'd0 - opa) : opa;
                        divisor_r <= (signed_div && opb[31]) ? (32'd0 - opb) : opb;
                        neg_quo_r <= signed_div && (opa[31] ^ opb[31]);
                        neg_rem_r <= signed_div && opa[31];
                    end
                end
                DIV_BYZERO: begin
                    // Raw values already carry the dividend's sign; no fix-up
                    quo_r     <= 32'hFFFF_FFFF;
                    rem_r     <= opa;
                    neg_quo_r <= 1'b0;
                    neg_rem_r <= 1'b0;
                end
                DIV_ON: begin
                    if (!annul) begin
                        cnt_r <= cnt_r + 6'd1;
                        if (!diff_s[32]) begin
                            rem_r <= diff_s[31:0];
                            quo_r <= {quo_r[30:0], 1'b1};
                        end else begin
                            rem_r <= partial_s[31:0];
                            quo_r <= {quo_r[30:0], 1'b0};
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Output logic: sign fix-up and ready flag
    always_comb begin
        quo_fix_s = neg_quo_r ? (32'd0 - quo_r) : quo_r;
        rem_fix_s = neg_rem_r ? (32'd0 - rem_r) : rem_r;
        result    = {rem_fix_s, quo_fix_s};
        ready     = (state_r == DIV_END);
    end

endmodule

// File: rtl/ex.sv
// MIPS execute stage: result mux, multiplier, HI/LO pair and divide stall.
// Define EX_DIV_EN to enable DIV/DIVU; otherwise they behave as unknown ops.
module ex
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic        div_op_s;
    logic        div_ready_s;
    logic [63:0] div_res_s;
    logic        mul_sext_s;
    logic [63:0] mul_s;
    logic [31:0] result_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;
    logic        hi_we_s;
    logic        lo_we_s;

`ifdef EX_DIV_EN
    assign div_op_s = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
`else
    assign div_op_s = 1'b0;
`endif

    ex_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_op_s),
        .signed_div (aluop_i == EXE_DIV_OP),
        .annul      (~div_op_s),
        .opa        (reg1_i),
        .opb        (reg2_i),
        .result     (div_res_s),
        .ready      (div_ready_s)
    );

    assign mul_sext_s = (aluop_i == EXE_MULT_OP);
    assign mul_s = {{32{mul_sext_s & reg1_i[31]}}, reg1_i} *
                   {{32{mul_sext_s & reg2_i[31]}}, reg2_i};

    // Result mux by class, then by operation
    always_comb begin
        result_s = 32'd0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  result_s = reg1_i | reg2_i;
                    EXE_AND_OP: result_s = reg1_i & reg2_i;
                    EXE_XOR_OP: result_s = reg1_i ^ reg2_i;
                    EXE_NOR_OP: result_s = ~(reg1_i | reg2_i);
                    default:    result_s = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: result_s = reg2_i << reg1_i[4:0];
                    EXE_SRL_OP: result_s = reg2_i >> reg1_i[4:0];
                    EXE_SRA_OP: result_s = $signed(reg2_i) >>> reg1_i[4:0];
                    default:    result_s = 32'd0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADDU_OP: result_s = reg1_i + reg2_i;
                    EXE_SUBU_OP: result_s = reg1_i - reg2_i;
                    EXE_SLT_OP:  result_s = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
                    EXE_SLTU_OP: result_s = {31'd0, (reg1_i < reg2_i)};
                    default:     result_s = 32'd0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: result_s = hi_r;
                    EXE_MFLO_OP: result_s = lo_r;
                    default:     result_s = 32'd0;
                endcase
            end
            default: result_s = 32'd0;
        endcase
    end

    // HI/LO write selection; a divide commits only in its END cycle
    always_comb begin
        hi_we_s  = 1'b0;
        lo_we_s  = 1'b0;
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        case (aluop_i)
            EXE_MULT_OP, EXE_MULTU_OP: begin
                hi_we_s  = 1'b1;
                lo_we_s  = 1'b1;
                hi_nxt_s = mul_s[63:32];
                lo_nxt_s = mul_s[31:0];
            end
            EXE_MTHI_OP: begin
                hi_we_s  = 1'b1;
                hi_nxt_s = reg1_i;
            end
            EXE_MTLO_OP: begin
                lo_we_s  = 1'b1;
                lo_nxt_s = reg1_i;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                if (div_op_s && div_ready_s) begin
                    hi_we_s  = 1'b1;
                    lo_we_s  = 1'b1;
                    hi_nxt_s = div_res_s[63:32];
                    lo_nxt_s = div_res_s[31:0];
                end else begin
                    hi_we_s = 1'b0;
                    lo_we_s = 1'b0;
                end
            end
            default: begin
                hi_we_s = 1'b0;
                lo_we_s = 1'b0;
            end
        endcase
    end

    // HI/LO register pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (hi_we_s) begin
                hi_r <= hi_nxt_s;
            end
            if (lo_we_s) begin
                lo_r <= lo_nxt_s;
            end
        end
    end

    // Reset forces the combinational write-back outputs low immediately
    assign wd_o       = rst ? wd_i : 5'd0;
    assign wreg_o     = rst & wreg_i;
    assign wdata_o    = rst ? result_s : 32'd0;
    assign stallreq_o = rst & div_op_s & ~div_ready_s;
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage; divide tests run when
// EX_DIV_EN is defined, otherwise DIV/DIVU are checked as inert ops.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop_i = 8'd0;
    logic [2:0]  alusel_i = 3'd0;
    logic [31:0] reg1_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
    endtask

    // Applies an op at a falling edge and counts stalled cycles (bounded);
    // returns one cycle after the unstalled END cycle, with a NOP applied.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int cycles);
        @(negedge clk);
        set_op(op, EXE_RES_NOP, a, b);
        #1;
        cycles = 0;
        while (stallreq_o && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #1;
    endtask

    task automatic test_reset;
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2);
        wd_i = 5'd5;
        wreg_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (wd_o !== 5'd0) begin n_fail++; $display("FAIL rst_wd: got %h want 00", wd_o); end
        n_tests++; if (wreg_o !== 1'b0) begin n_fail++; $display("FAIL rst_wreg: got %b want 0", wreg_o); end
        n_tests++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", wdata_o); end
        n_tests++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stallreq_o); end
        n_tests++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL rst_hilo: got %h want 0", {hi_o, lo_o}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_logic;
        @(negedge clk);
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h00F0F0F0);
        wd_i = 5'd3;
        wreg_i = 1'b1;
        #1;
        n_tests++; if (wdata_o !== 32'h00F0FFF0) begin n_fail++; $display("FAIL or_data: got %h want 00f0fff0", wdata_o); end
        n_tests++; if (wd_o !== 5'd3) begin n_fail++; $display("FAIL or_wd: got %h want 03", wd_o); end
        n_tests++; if (wreg_o !== 1'b1) begin n_fail++; $display("FAIL or_wreg: got %b want 1", wreg_o); end
        aluop_i = EXE_AND_OP; #1;
        n_tests++; if (wdata_o !== 32'h0000F000) begin n_fail++; $display("FAIL and_data: got %h want 0000f000", wdata_o); end
        aluop_i = EXE_XOR_OP; #1;
        n_tests++; if (wdata_o !== 32'h00F00FF0) begin n_fail++; $display("FAIL xor_data: got %h want 00f00ff0", wdata_o); end
        aluop_i = EXE_NOR_OP; #1;
        n_tests++; if (wdata_o !== 32'hFF0F000F) begin n_fail++; $display("FAIL nor_data: got %h want ff0f000f", wdata_o); end
        wreg_i = 1'b0;
    endtask

    task automatic test_shift;
        @(negedge clk);
        set_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000000F);
        #1;
        n_tests++; if (wdata_o !== 32'h000000F0) begin n_fail++; $display("FAIL sll_data: got %h want 000000f0", wdata_o); end
        aluop_i = EXE_SRL_OP; #1;
        n_tests++; if (wdata_o !== 32'h08000000) begin n_fail++; $display("FAIL srl_data: got %h want 08000000", wdata_o); end
        aluop_i = EXE_SRA_OP; #1;
        n_tests++; if (wdata_o !== 32'hF8000000) begin n_fail++; $display("FAIL sra_data: got %h want f8000000", wdata_o); end
    endtask

    task automatic test_arith;
        @(negedge clk);
        set_op(EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd2);
        #1;
        n_tests++; if (wdata_o !== 32'h00000001) begin n_fail++; $display("FAIL addu_data: got %h want 00000001", wdata_o); end
        set_op(EXE_SUBU_OP, EXE_RES_ARITH, 32'd1, 32'd2); #1;
        n_tests++; if (wdata_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL subu_data: got %h want ffffffff", wdata_o); end
        set_op(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1); #1;
        n_tests++; if (wdata_o !== 32'd1) begin n_fail++; $display("FAIL slt_data: got %h want 00000001", wdata_o); end
        aluop_i = EXE_SLTU_OP; #1;
        n_tests++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL sltu_data: got %h want 00000000", wdata_o); end
    endtask

    task automatic test_mult;
        @(negedge clk);
        set_op(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3);
        #1;
        n_tests++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL mult_stall: got %b want 0", stallreq_o); end
        @(negedge clk);
        set_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0);
        #1;
        n_tests++; if (wdata_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mfhi_data: got %h want ffffffff", wdata_o); end
        @(negedge clk);
        aluop_i = EXE_MFLO_OP;
        #1;
        n_tests++; if (wdata_o !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mflo_data: got %h want fffffffa", wdata_o); end
        @(negedge clk);
        set_op(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #1;
        n_tests++; if ({hi_o, lo_o} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL multu_hilo: got %h want fffffffe00000001", {hi_o, lo_o}); end
    endtask

    task automatic test_mthilo;
        @(negedge clk);
        set_op(EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 32'd0);
        @(negedge clk);
        set_op(EXE_MTLO_OP, EXE_RES_NOP, 32'h9ABCDEF0, 32'd0);
        @(negedge clk);
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #1;
        n_tests++; if (hi_o !== 32'h12345678) begin n_fail++; $display("FAIL mthi: got %h want 12345678", hi_o); end
        n_tests++; if (lo_o !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo: got %h want 9abcdef0", lo_o); end
    endtask

    task automatic test_unknown;
        @(negedge clk);
        set_op(8'hFF, EXE_RES_ARITH, 32'h11111111, 32'h22222222);
        #1;
        n_tests++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL unk_data: got %h want 0", wdata_o); end
        @(negedge clk);
        #1;
        n_tests++; if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin n_fail++; $display("FAIL unk_hilo: got %h want 123456789abcdef0", {hi_o, lo_o}); end
    endtask

`ifdef EX_DIV_EN
    task automatic test_div;
        int cyc;
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, cyc);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL divu_stall: got %0d want 33", cyc); end
        n_tests++; if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_hilo: got %h want 000000020000000e", {hi_o, lo_o}); end
        run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, cyc);
        n_tests++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL div_neg_hilo: got %h want fffffffffffffffd", {hi_o, lo_o}); end
        run_div(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_tests++; if ({hi_o, lo_o} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_wrap_hilo: got %h want 0000000080000000", {hi_o, lo_o}); end
        run_div(EXE_DIV_OP, 32'd5, 32'd0, cyc);
        n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL divz_stall: got %0d want 2", cyc); end
        n_tests++; if ({hi_o, lo_o} !== 64'h00000005_FFFFFFFF) begin n_fail++; $display("FAIL divz_hilo: got %h want 00000005ffffffff", {hi_o, lo_o}); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #1;
        n_tests++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stallreq_o); end
        repeat (40) @(negedge clk);
        #1;
        n_tests++; if ({hi_o, lo_o} !== 64'h00000005_FFFFFFFF) begin n_fail++; $display("FAIL flush_hilo: got %h want 00000005ffffffff", {hi_o, lo_o}); end
    endtask

    task automatic test_reset_mid_div;
        int cyc;
        @(negedge clk);
        set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
        #1;
        cyc = 0;
        while (stallreq_o && cyc < 10) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        n_tests++; if (cyc != 10) begin n_fail++; $display("FAIL mid_reach: got %0d want 10", cyc); end
        rst = 1'b0;
        #1;
        n_tests++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %b want 0", stallreq_o); end
        n_tests++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL mid_rst_hilo: got %h want 0", {hi_o, lo_o}); end
        @(negedge clk);
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        rst = 1'b1;
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, cyc);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL post_rst_stall: got %0d want 33", cyc); end
        n_tests++; if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL post_rst_hilo: got %h want 000000020000000e", {hi_o, lo_o}); end
    endtask
`else
    task automatic test_div_disabled;
        int stalls;
        @(negedge clk);
        set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stallreq_o !== 1'b0) stalls++;
            @(negedge clk);
        end
        #1;
        n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL nodiv_stall: got %0d want 0", stalls); end
        n_tests++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL nodiv_data: got %h want 0", wdata_o); end
        n_tests++; if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin n_fail++; $display("FAIL nodiv_hilo: got %h want 123456789abcdef0", {hi_o, lo_o}); end
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_arith();
        test_mult();
        test_mthilo();
        test_unknown();
`ifdef EX_DIV_EN
        test_div();
        test_flush();
        test_reset_mid_div();
`else
        test_div_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
